// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq
//   Single-bus datapath with its own T-step sequencer. The register file, Y,
//   Z (ZHI/ZLO), HI, LO and the ALU share one internal bus. The sequencer
//   picks the bus source from its state instead of from one-hot register
//   output enables. Each accepted register-register operation runs
//   IDLE -> T1 -> T2 -> T3 -> IDLE.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   clr       asynchronous active-low reset
//   op_valid  operation request            op_ready  op accepted this cycle when high
//   opcode    0 ADD,1 SUB,2 AND,3 OR,4 NOT,5 SHL,6 SHR,7 MUL
//   rs/rt/rd  source / destination registers (rd unused for MUL)
//   ld_valid  external load request        ld_ready  load accepted this cycle
//   ld_addr   load target register         ld_data   load value
//   done      one-cycle pulse in the write-back step (T3)
//   bus_sel   bus source: 0 none,1 Rs,2 Rt,3 ZLO,4 load data
//   dbg_addr  debug read address           dbg_data  R[dbg_addr], combinational
//   hi_out    HI register                  lo_out    LO register
module bus_datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             done,
  output logic [2:0]       bus_sel,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_SHL, OP_SHR, OP_MUL
  } op_e;

  state_e            state_q;
  op_e               opc_q;
  logic [AW-1:0]     rs_q, rt_q, rd_q;
  logic [WIDTH-1:0]  y_q, zhi_q, zlo_q, hi_q, lo_q;
  logic              done_q;
  logic [WIDTH-1:0]  rf_q [NREGS];

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;

  // Load has priority over an op in IDLE; the op simply stays pending.
  assign op_ready = (state_q == S_IDLE) && !ld_valid;
  assign ld_ready = (state_q == S_IDLE) && ld_valid;

  // Bus source is a pure function of the sequencer step.
  always_comb begin
    bus     = '0;
    bus_sel = 3'd0;
    case (state_q)
      S_IDLE: if (ld_valid) begin bus = ld_data;    bus_sel = 3'd4; end
      S_T1:   begin               bus = rf_q[rs_q]; bus_sel = 3'd1; end
      S_T2:   begin               bus = rf_q[rt_q]; bus_sel = 3'd2; end
      S_T3:   begin               bus = zlo_q;      bus_sel = 3'd3; end
      default: ;
    endcase
  end

  // ALU: Y is the first operand, the bus (Rt in T2) the second.
  always_comb begin
    alu_res = '0;
    case (opc_q)
      OP_ADD: alu_res = {{WIDTH{1'b0}}, y_q + bus};
      OP_SUB: alu_res = {{WIDTH{1'b0}}, y_q - bus};
      OP_AND: alu_res = {{WIDTH{1'b0}}, y_q & bus};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, y_q | bus};
      OP_NOT: alu_res = {{WIDTH{1'b0}}, ~y_q};
      OP_SHL: alu_res = {{WIDTH{1'b0}}, y_q << bus[SW-1:0]};
      OP_SHR: alu_res = {{WIDTH{1'b0}}, y_q >> bus[SW-1:0]};
      OP_MUL: alu_res = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus};
      default: alu_res = '0;
    endcase
  end

  // Both register-file writers (load in IDLE, write-back in T3) take their
  // data from the bus, so only the address differs.
  assign wr_en   = ld_ready || ((state_q == S_T3) && (opc_q != OP_MUL));
  assign wr_addr = ld_ready ? ld_addr : rd_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wr_addr] <= bus;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      opc_q   <= OP_ADD;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            opc_q   <= op_e'(opcode);
            rs_q    <= rs;
            rt_q    <= rt;
            rd_q    <= rd;
            state_q <= S_T1;
          end
        end
        S_T1: begin
          y_q     <= bus;
          state_q <= S_T2;
        end
        S_T2: begin
          {zhi_q, zlo_q} <= alu_res;
          done_q         <= 1'b1;   // registered so it is high exactly in T3
          state_q        <= S_T3;
        end
        S_T3: begin
          if (opc_q == OP_MUL) begin
            hi_q <= zhi_q;
            lo_q <= zlo_q;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign dbg_data = rf_q[dbg_addr];
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
module tb_bus_datapath_seq;

  logic        clk = 1'b0;
  logic        clr;
  int          cyc = 0;

  // DUT 1: WIDTH=32, NREGS=16
  logic        op_valid, op_ready, ld_valid, ld_ready, done;
  logic [2:0]  opcode, bus_sel;
  logic [3:0]  rs, rt, rd, ld_addr, dbg_addr;
  logic [31:0] ld_data, dbg_data, hi_out, lo_out;

  // DUT 2: WIDTH=16, NREGS=8
  logic        op_valid2, op_ready2, ld_valid2, ld_ready2, done2;
  logic [2:0]  opcode2, bus_sel2;
  logic [2:0]  rs_2, rt_2, rd_2, ld_addr2, dbg_addr2;
  logic [15:0] ld_data2, dbg_data2, hi_out2, lo_out2;

  bus_datapath_seq #(.WIDTH(32), .NREGS(16)) dut (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .done(done), .bus_sel(bus_sel), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .hi_out(hi_out), .lo_out(lo_out));

  bus_datapath_seq #(.WIDTH(16), .NREGS(8)) dut2 (
    .clk(clk), .clr(clr), .op_valid(op_valid2), .op_ready(op_ready2), .opcode(opcode2),
    .rs(rs_2), .rt(rt_2), .rd(rd_2), .ld_valid(ld_valid2), .ld_addr(ld_addr2), .ld_data(ld_data2),
    .ld_ready(ld_ready2), .done(done2), .bus_sel(bus_sel2), .dbg_addr(dbg_addr2),
    .dbg_data(dbg_data2), .hi_out(hi_out2), .lo_out(lo_out2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  opc;
    logic [3:0]  rs, rt, rd;
    logic [31:0] a, b;
    logic [63:0] ex;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] exp_rd, exp_hi, exp_lo;
  } sb_t;

  vec_t        vecs [12];
  sb_t         sbq [$];
  logic [31:0] mreg [16];
  logic [31:0] mhi, mlo;
  int          n_checks = 0;
  int          n_pass = 0;
  int          acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1 check("ld_ready", 64'(ld_ready), 64'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    mreg[a] = d;
    $display("load R%0d <= %08h", a, d);
  endtask

  task automatic issue(input logic [2:0] opc, input logic [3:0] s, input logic [3:0] t,
                       input logic [3:0] d, input logic [63:0] ex);
    bit ok = 1'b0;
    sb_t e;
    op_valid = 1'b1; opcode = opc; rs = s; rt = t; rd = d;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (op_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("op_accept_timeout", 64'd0, 64'd1);
      op_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    e.rd = d;
    if (opc == 3'd7) begin
      mhi = ex[63:32]; mlo = ex[31:0];
      e.exp_rd = mreg[d];
    end else begin
      mreg[d] = ex[31:0];
      e.exp_rd = ex[31:0];
    end
    e.exp_hi = mhi; e.exp_lo = mlo;
    sbq.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
    #1 check("t1_bus_sel", 64'(bus_sel), 64'd1);
    check("t1_op_ready", 64'(op_ready), 64'd0);
  endtask

  task automatic wait_done();
    bit found = 1'b0;
    sb_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 check("busy_ld_ready", 64'(ld_ready), 64'd0);
      if (done) begin found = 1'b1; break; end
    end
    check("done_latency", found ? 64'(cyc - acc_cyc) : 64'd99, 64'd3);
    if (found) check("t3_bus_sel", 64'(bus_sel), 64'd3);
    ld_valid = 1'b0;
    @(negedge clk);
    #1 check("done_one_cycle", 64'(done), 64'd0);
    if (sbq.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sbq.pop_front();
    dbg_addr = e.rd;
    #1;
    $display("op done: R%0d=%08h HI=%08h LO=%08h", e.rd, dbg_data, hi_out, lo_out);
    check("result_rd", 64'(dbg_data), 64'(e.exp_rd));
    check("result_hi", 64'(hi_out), 64'(e.exp_hi));
    check("result_lo", 64'(lo_out), 64'(e.exp_lo));
  endtask

  task automatic wait_done2(output int c);
    c = -100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (done2) begin c = cyc; break; end
    end
  endtask

  initial begin
    int a1, d2, a2;
    bit seen;
    vecs[0]  = '{3'd0, 4'd1,  4'd2,  4'd3,  32'd5,          32'd7,          64'd12};
    vecs[1]  = '{3'd1, 4'd4,  4'd5,  4'd6,  32'd0,          32'd1,          64'hFFFF_FFFF};
    vecs[2]  = '{3'd2, 4'd1,  4'd2,  4'd7,  32'hF0F0_1234,  32'h0FF0_FFFF,  64'h00F0_1234};
    vecs[3]  = '{3'd3, 4'd8,  4'd9,  4'd10, 32'hA5A5_0000,  32'h0000_5A5A,  64'hA5A5_5A5A};
    vecs[4]  = '{3'd4, 4'd1,  4'd2,  4'd11, 32'h0000_FFFF,  32'h0001_2345,  64'hFFFF_0000};
    vecs[5]  = '{3'd5, 4'd1,  4'd2,  4'd12, 32'h0001_0000,  32'd4,          64'h0010_0000};
    vecs[6]  = '{3'd6, 4'd1,  4'd2,  4'd13, 32'h8000_0000,  32'h23,         64'h1000_0000};
    vecs[7]  = '{3'd7, 4'd1,  4'd1,  4'd12, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[8]  = '{3'd7, 4'd1,  4'd2,  4'd0,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[9]  = '{3'd0, 4'd15, 4'd15, 4'd15, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'hFFFF_FFFE};
    vecs[10] = '{3'd0, 4'd1,  4'd2,  4'd3,  32'hFFFF_FFFF,  32'd2,          64'd1};
    vecs[11] = '{3'd5, 4'd1,  4'd2,  4'd4,  32'd1,          32'h1F,         64'h8000_0000};

    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mhi = '0; mlo = '0;
    clr = 1'b0;
    op_valid = 0; opcode = 0; rs = 0; rt = 0; rd = 0; ld_valid = 0; ld_addr = 0; ld_data = 0; dbg_addr = 0;
    op_valid2 = 0; opcode2 = 0; rs_2 = 0; rt_2 = 0; rd_2 = 0; ld_valid2 = 0; ld_addr2 = 0; ld_data2 = 0; dbg_addr2 = 0;
    repeat (3) @(negedge clk);
    clr = 1'b1;

    // Reset state
    #1 check("rst_op_ready", 64'(op_ready), 64'd1);
    check("rst_ld_ready", 64'(ld_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bus_sel", 64'(bus_sel), 64'd0);
    check("rst_hi", 64'(hi_out), 64'd0);
    check("rst_lo", 64'(lo_out), 64'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 check("rst_reg", 64'(dbg_data), 64'd0);
    end
    @(negedge clk);

    // Table-driven ops
    foreach (vecs[i]) begin
      load(vecs[i].rs, vecs[i].a);
      if (vecs[i].rt != vecs[i].rs) load(vecs[i].rt, vecs[i].b);
      $display("vec %0d: op=%0d rs=%0d rt=%0d rd=%0d", i, vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].rd);
      issue(vecs[i].opc, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].ex);
      wait_done();
    end

    // Load and op in the same IDLE cycle: load wins, op uses the loaded value
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'd9;
    op_valid = 1'b1; opcode = 3'd0; rs = 4'd1; rt = 4'd1; rd = 4'd2;
    #1 check("coll_op_ready", 64'(op_ready), 64'd0);
    check("coll_ld_ready", 64'(ld_ready), 64'd1);
    check("coll_bus_sel", 64'(bus_sel), 64'd4);
    @(negedge clk);
    ld_valid = 1'b0; mreg[1] = 32'd9;
    issue(3'd0, 4'd1, 4'd1, 4'd2, 64'd18);
    wait_done();

    // Load requested during T1..T3 is not written
    load(4'd5, 32'h55);
    load(4'd1, 32'd21);
    issue(3'd0, 4'd1, 4'd1, 4'd4, 64'd42);
    ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'hDEAD_BEEF;
    wait_done();
    dbg_addr = 4'd5;
    #1 check("busy_load_ignored", 64'(dbg_data), 64'h55);

    // Back-to-back: R3=R1+R1, then R3=R3+R3, accepted 4 cycles apart
    @(negedge clk);
    load(4'd1, 32'd5);
    issue(3'd0, 4'd1, 4'd1, 4'd3, 64'd10);
    a1 = acc_cyc;
    op_valid = 1'b1; opcode = 3'd0; rs = 4'd3; rt = 4'd3; rd = 4'd3;
    wait_done();
    issue(3'd0, 4'd3, 4'd3, 4'd3, 64'd20);
    check("b2b_spacing", 64'(acc_cyc - a1), 64'd4);
    wait_done();

    // Reset during T2: op abandoned, everything cleared
    @(negedge clk);
    load(4'd2, 32'd4);
    issue(3'd0, 4'd1, 4'd2, 4'd6, 64'd9);
    @(negedge clk);
    #1 clr = 1'b0;
    #1 check("clr_done", 64'(done), 64'd0);
    dbg_addr = 4'd1;
    #1 check("clr_r1", 64'(dbg_data), 64'd0);
    check("clr_hi", 64'(hi_out), 64'd0);
    check("clr_lo", 64'(lo_out), 64'd0);
    sbq.delete();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    @(negedge clk);
    clr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1 if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("clr_no_done", 64'(seen), 64'd0);
    #1 check("clr_op_ready", 64'(op_ready), 64'd1);
    dbg_addr = 4'd6;
    #1 check("clr_r6", 64'(dbg_data), 64'd0);
    $display("reset during T2: R6=%08h op_ready=%0d", dbg_data, op_ready);

    // WIDTH=16, NREGS=8 instance: back-to-back and wrap-around
    @(negedge clk);
    ld_valid2 = 1'b1; ld_addr2 = 3'd1; ld_data2 = 16'd5;
    @(negedge clk);
    ld_valid2 = 1'b0;
    op_valid2 = 1'b1; opcode2 = 3'd0; rs_2 = 3'd1; rt_2 = 3'd1; rd_2 = 3'd3;
    #1 check("w16_op_ready", 64'(op_ready2), 64'd1);
    a2 = cyc;
    @(negedge clk);
    rs_2 = 3'd3; rt_2 = 3'd3; rd_2 = 3'd3;
    wait_done2(d2);
    check("w16_latency", 64'(d2 - a2), 64'd3);
    @(negedge clk);
    dbg_addr2 = 3'd3;
    #1 check("w16_first", 64'(dbg_data2), 64'd10);
    check("w16_ready_after_done", 64'(op_ready2), 64'd1);
    check("w16_spacing", 64'(cyc - a2), 64'd4);
    @(negedge clk);
    op_valid2 = 1'b0;
    wait_done2(d2);
    @(negedge clk);
    #1 check("w16_b2b", 64'(dbg_data2), 64'd20);
    $display("w16: R3=%04h", dbg_data2);
    op_valid2 = 1'b1; opcode2 = 3'd1; rs_2 = 3'd0; rt_2 = 3'd1; rd_2 = 3'd5;
    @(negedge clk);
    op_valid2 = 1'b0;
    wait_done2(d2);
    check("w16_sub_done_seen", 64'(d2 > 0), 64'd1);
    @(negedge clk);
    dbg_addr2 = 3'd5;
    #1 check("w16_sub", 64'(dbg_data2), 64'hFFFB);
    check("w16_hi", 64'(hi_out2), 64'd0);
    $display("w16: R5=%04h", dbg_data2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
